bp_fetch_ctrl: RTL and testbench

IF-stage PC generator and prediction-tracking pipeline for the branch-prediction CPU. It owns the fetch PC register and chooses next PC from the BTB prediction, sequential PC+4, or an EX-stage correction. It carries each fetched instruction's prediction (PredF, NPC_PredF) through ID to EX, where it checks the prediction against the resolved branch. On a mispredict it redirects fetch and flushes the wrong-path instructions. It sits directly upstream of the BTB (drives PCF, consumes PredF/NPC_PredF) and downstream of it in EX (drives PCE/PredE/NPC_PredE back into the BTB update port).

---
 rtl/bp_fetch_ctrl.sv | 155 +++++++++++++++
 tb/tb_bp_fetch_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/bp_fetch_ctrl.sv
// IF-stage PC generator with prediction tracking through ID/EX and mispredict redirect.
// Define BP_STATS_EN to build the branch/mispredict statistics counters.
module bp_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushE_in,
  input  logic        PredF,
  input  logic [31:0] NPC_PredF,
  input  logic        BranchE,
  input  logic        IsBranchE,
  input  logic [31:0] BrNPC,
  output logic [31:0] PCF,
  output logic [31:0] PCE,
  output logic        PredE,
  output logic [31:0] NPC_PredE,
  output logic        ValidE,
  output logic        MispredE,
  output logic        FlushD,
  output logic        FlushE,
  output logic [31:0] BranchCnt,
  output logic [31:0] MispredCnt
);

  logic [31:0] pcf_reg, pcf_next;

  logic [31:0] pcd_reg, pcd_next;
  logic        predd_reg, predd_next;
  logic [31:0] npcd_reg, npcd_next;
  logic        validd_reg, validd_next;

  logic [31:0] pce_reg, pce_next;
  logic        prede_reg, prede_next;
  logic [31:0] npce_reg, npce_next;
  logic        valide_reg, valide_next;

  logic        mispred;
  logic [31:0] correct_npc;

  // Any disagreement in direction, or in target when both say taken, is a mispredict.
  always_comb begin
    mispred = valide_reg & ((prede_reg & ~BranchE) |
                            (~prede_reg & BranchE) |
                            (prede_reg & BranchE & (npce_reg != BrNPC)));
    correct_npc = BranchE ? BrNPC : (pce_reg + 32'd4);
  end

  always_comb begin
    pcf_next = pcf_reg + 32'd4;
    if (mispred)
      pcf_next = correct_npc;
    else if (StallF)
      pcf_next = pcf_reg;
    else if (PredF)
      pcf_next = NPC_PredF;
  end

  always_comb begin
    pcd_next    = pcd_reg;
    predd_next  = predd_reg;
    npcd_next   = npcd_reg;
    validd_next = validd_reg;
    if (mispred) begin
      pcd_next    = 32'd0;
      predd_next  = 1'b0;
      npcd_next   = 32'd0;
      validd_next = 1'b0;
    end else if (StallD) begin
      validd_next = validd_reg;
    end else if (StallF) begin
      validd_next = 1'b0;
    end else begin
      pcd_next    = pcf_reg;
      predd_next  = PredF;
      npcd_next   = NPC_PredF;
      validd_next = 1'b1;
    end
  end

  // Bubbles present all-zero fields so the BTB update port sees a harmless PC 0.
  always_comb begin
    pce_next    = pcd_reg;
    prede_next  = predd_reg;
    npce_next   = npcd_reg;
    valide_next = validd_reg;
    if (mispred || FlushE_in || StallD) begin
      pce_next    = 32'd0;
      prede_next  = 1'b0;
      npce_next   = 32'd0;
      valide_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcf_reg    <= RESET_PC;
      pcd_reg    <= 32'd0;
      predd_reg  <= 1'b0;
      npcd_reg   <= 32'd0;
      validd_reg <= 1'b0;
      pce_reg    <= 32'd0;
      prede_reg  <= 1'b0;
      npce_reg   <= 32'd0;
      valide_reg <= 1'b0;
    end else begin
      pcf_reg    <= pcf_next;
      pcd_reg    <= pcd_next;
      predd_reg  <= predd_next;
      npcd_reg   <= npcd_next;
      validd_reg <= validd_next;
      pce_reg    <= pce_next;
      prede_reg  <= prede_next;
      npce_reg   <= npce_next;
      valide_reg <= valide_next;
    end
  end

`ifdef BP_STATS_EN
  logic [31:0] branch_cnt_reg;
  logic [31:0] mispred_cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_cnt_reg  <= 32'd0;
      mispred_cnt_reg <= 32'd0;
    end else begin
      if (valide_reg && IsBranchE)
        branch_cnt_reg <= branch_cnt_reg + 32'd1;
      if (mispred)
        mispred_cnt_reg <= mispred_cnt_reg + 32'd1;
    end
  end

  assign BranchCnt  = branch_cnt_reg;
  assign MispredCnt = mispred_cnt_reg;
`else
  logic unused_is_branch;
  assign unused_is_branch = IsBranchE;
  assign BranchCnt  = 32'd0;
  assign MispredCnt = 32'd0;
`endif

  assign PCF       = pcf_reg;
  assign PCE       = pce_reg;
  assign PredE     = prede_reg;
  assign NPC_PredE = npce_reg;
  assign ValidE    = valide_reg;
  assign MispredE  = mispred;
  assign FlushD    = mispred;
  assign FlushE    = mispred;

endmodule

// File: tb/tb_bp_fetch_ctrl.sv
// Directed bench for bp_fetch_ctrl: PC sequencing, prediction check, redirects, stalls, reset.
module tb_bp_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        StallF, StallD, FlushE_in, PredF;
  logic [31:0] NPC_PredF;
  logic        BranchE, IsBranchE;
  logic [31:0] BrNPC;
  logic [31:0] PCF, PCE, NPC_PredE, BranchCnt, MispredCnt;
  logic        PredE, ValidE, MispredE, FlushD, FlushE;

  int n_checks = 0;
  int n_fail   = 0;

  bp_fetch_ctrl dut (
    .clk(clk), .rst(rst), .StallF(StallF), .StallD(StallD), .FlushE_in(FlushE_in),
    .PredF(PredF), .NPC_PredF(NPC_PredF), .BranchE(BranchE), .IsBranchE(IsBranchE),
    .BrNPC(BrNPC), .PCF(PCF), .PCE(PCE), .PredE(PredE), .NPC_PredE(NPC_PredE),
    .ValidE(ValidE), .MispredE(MispredE), .FlushD(FlushD), .FlushE(FlushE),
    .BranchCnt(BranchCnt), .MispredCnt(MispredCnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    BranchE = 1'b0; IsBranchE = 1'b0; BrNPC = 32'd0;
  endtask

  task automatic resolve(input logic taken, input logic [31:0] target);
    BranchE = taken; IsBranchE = 1'b1; BrNPC = target;
    #1;
  endtask

  task automatic check_counts(input string tag, input int br, input int mis);
`ifdef BP_STATS_EN
    check({tag, "_bcnt"}, BranchCnt, br);
    check({tag, "_mcnt"}, MispredCnt, mis);
`else
    check({tag, "_bcnt"}, BranchCnt, 32'd0);
    check({tag, "_mcnt"}, MispredCnt, 32'd0);
`endif
  endtask

  initial begin
    rst = 1'b1; StallF = 0; StallD = 0; FlushE_in = 0; PredF = 0; NPC_PredF = 0;
    clear_ex();
    step(); step();
    check("rst_pcf", PCF, 32'h0);
    check("rst_valide", ValidE, 0);
    check("rst_mispred", MispredE, 0);
    check_counts("rst", 0, 0);
    rst = 1'b0;

    // Sequential fetch: 0 in ID after first edge, in EX after second
    step(); check("seq_pcf1", PCF, 32'h4); check("seq_valide1", ValidE, 0);
    step(); check("seq_pcf2", PCF, 32'h8); check("seq_valide2", ValidE, 1);
    check("seq_pce2", PCE, 32'h0);

    // Predicted taken at PCF=8 to 0x40, then confirmed correct in EX
    PredF = 1; NPC_PredF = 32'h40;
    step(); check("pred_pcf", PCF, 32'h40);
    PredF = 0; NPC_PredF = 0;
    step(); check("pred_pcf_seq", PCF, 32'h44);
    check("pred_pce", PCE, 32'h8); check("pred_prede", PredE, 1);
    check("pred_npce", NPC_PredE, 32'h40);
    resolve(1, 32'h40);
    check("pred_ok_mispred", MispredE, 0); check("pred_ok_flushd", FlushD, 0);
    step(); clear_ex(); check("pred_ok_pcf", PCF, 32'h48);

    // Redirect to 0x10 (PCE=0x40 not predicted, taken)
    resolve(1, 32'h10);
    check("rd10_mispred", MispredE, 1); check("rd10_flushe", FlushE, 1);
    step(); clear_ex();
    check("rd10_pcf", PCF, 32'h10); check("rd10_valide", ValidE, 0); check("rd10_pce", PCE, 0);
    step(); check("rd10_valide2", ValidE, 0);
    step(); check("rd10_pce3", PCE, 32'h10); check("rd10_valide3", ValidE, 1);

    // Not-predicted taken at PCE=0x10 to 0x80
    resolve(1, 32'h80);
    check("npt_mispred", MispredE, 1);
    step(); clear_ex();
    check("npt_pcf", PCF, 32'h80); check("npt_valide", ValidE, 0);
    check_counts("npt", 3, 2);

    // Reach PCE=0x80, redirect to 0x20
    step(); step(); check("to20_pce", PCE, 32'h80);
    resolve(1, 32'h20);
    step(); clear_ex(); check("to20_pcf", PCF, 32'h20);

    // Predicted taken at 0x20 (target 0x70) but not taken -> 0x24
    PredF = 1; NPC_PredF = 32'h70;
    step(); check("pnt_pcf_pred", PCF, 32'h70);
    PredF = 0; NPC_PredF = 0;
    step(); check("pnt_pce", PCE, 32'h20); check("pnt_prede", PredE, 1);
    resolve(0, 32'h0);
    check("pnt_mispred", MispredE, 1);
    step(); clear_ex(); check("pnt_pcf", PCF, 32'h24);

    // Predicted target 0x50, resolved target 0x60
    PredF = 1; NPC_PredF = 32'h50;
    step(); check("tgt_pcf_pred", PCF, 32'h50);
    PredF = 0; NPC_PredF = 0;
    step(); check("tgt_pce", PCE, 32'h24); check("tgt_npce", NPC_PredE, 32'h50);
    resolve(1, 32'h60);
    check("tgt_mispred", MispredE, 1);
    step(); clear_ex(); check("tgt_pcf", PCF, 32'h60);

    // Redirect to 0x28 so the stall happens with a full pipe at PCF=0x30
    step(); step(); check("to28_pce", PCE, 32'h60);
    resolve(1, 32'h28);
    step(); clear_ex(); check("to28_pcf", PCF, 32'h28);
    step(); step(); check("stall_pre_pcf", PCF, 32'h30); check("stall_pre_pce", PCE, 32'h28);

    StallF = 1; StallD = 1;
    step(); check("stall1_pcf", PCF, 32'h30); check("stall1_valide", ValidE, 0);
    step(); check("stall2_pcf", PCF, 32'h30); check("stall2_valide", ValidE, 0);
    check("stall2_pce", PCE, 32'h0);
    StallF = 0; StallD = 0;
    step(); check("unstall_pcf", PCF, 32'h34); check("unstall_pce", PCE, 32'h2C);
    check("unstall_valide", ValidE, 1);

    // Mispredict coincides with StallF/StallD: redirect wins
    StallF = 1; StallD = 1;
    resolve(1, 32'h90);
    check("stmis_mispred", MispredE, 1);
    step(); clear_ex(); StallF = 0; StallD = 0;
    check("stmis_pcf", PCF, 32'h90); check("stmis_valide", ValidE, 0);
    check_counts("stmis", 8, 7);

    // FlushE_in bubbles EX while ID still advances
    step(); FlushE_in = 1;
    step(); FlushE_in = 0;
    check("flush_valide", ValidE, 0); check("flush_pcf", PCF, 32'h98);
    step(); check("flush_pce", PCE, 32'h94); check("flush_valide2", ValidE, 1);

    // Redirect to 0x100, then asynchronous reset mid-cycle
    resolve(1, 32'h100);
    step(); clear_ex(); check("to100_pcf", PCF, 32'h100);
    check_counts("to100", 9, 8);
    #1; rst = 1'b1; #1;
    check("arst_pcf", PCF, 32'h0); check("arst_valide", ValidE, 0); check("arst_pce", PCE, 0);
    check_counts("arst", 0, 0);
    step(); rst = 1'b0;

    // PC wraparound from 0xFFFF_FFFC
    step(); step(); check("wrap_valide", ValidE, 1);
    resolve(1, 32'hFFFF_FFFC);
    step(); clear_ex(); check("wrap_pcf_top", PCF, 32'hFFFF_FFFC);
    step(); check("wrap_pcf_zero", PCF, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
